tableau_row_sequencer: RTL and testbench
========================================

TABLEAU_ROW_SEQUENCER -- requirements
Module: tableau_row_sequencer

Interface
REQ-001 SHALL have parameter num_qubit, default 4: number of qubits, which is also the number of stored stabilizer rows.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_new, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port start, input, 1 bit: begin one sequencing pass; sampled only in IDLE.
REQ-005 SHALL have port col_sel, input, clog2(num_qubit)+1 bits: target qubit column for the pass; latched on accepted start.
REQ-006 SHALL have port wr_en, input, 1 bit: row-bank write strobe.
REQ-007 SHALL have port wr_addr, input, clog2(num_qubit) bits: row index to write.
REQ-008 SHALL have port wr_literals, input, [1:0] x num_qubit: Pauli literals of the written row.
REQ-009 SHALL have port wr_phase, input, 1 bit: phase of the written row.
REQ-010 SHALL have port literals_out, output, [1:0] x num_qubit: current row presented to the Q/Q2 multiplier.
REQ-011 SHALL have port phase_out, output, 1 bit: phase of the presented row.
REQ-012 SHALL have ports ld_Q and ld_Q2, output, 1 bit each: load strobes for Q and Q2.
REQ-013 SHALL have port load_Q_mux, output, 1 bit: 0 = load Q/Q2 from P; 1 = load the Q x row product.
REQ-014 SHALL have port load_rotate_Q, output, 1 bit: held at 0 (load mode only).
REQ-015 SHALL have ports busy, output, 1 bit (pass in progress), and done, output, 1 bit (one-cycle end-of-pass pulse).

Function
REQ-016 SHALL encode literals as follows: bit1 = X component, bit0 = Z component (00 I, 01 Z, 10 X, 11 Y).
REQ-017 SHALL store num_qubit rows in a register bank; when wr_en=1 and state is IDLE, row[wr_addr] is written on the next edge; writes while busy are ignored.
REQ-018 SHALL implement FSM states IDLE, INIT, SCAN, DONE.
REQ-019 SHALL transition IDLE -> INIT on start=1, latching col_sel; start is ignored in every other state.
REQ-020 In INIT (one cycle), SHALL assert ld_Q=1, ld_Q2=1, load_Q_mux=0, then go to SCAN with row pointer = 0.
REQ-021 In SCAN, SHALL drive literals_out/phase_out combinationally from row[ptr] and set load_Q_mux=1.
REQ-022 In SCAN, ld_Q SHALL equal row[ptr][col_sel][1] and ld_Q2 SHALL equal row[ptr][col_sel][0].
REQ-023 In SCAN, SHALL increment ptr each cycle; when ptr = num_qubit-1 the next state is DONE.
REQ-024 In DONE (one cycle), SHALL assert done=1 with all strobes 0, then return to IDLE.
REQ-025 SHALL hold busy=1 in INIT, SCAN and DONE, and busy=0 in IDLE.
REQ-026 Latency: done SHALL assert exactly num_qubit+2 cycles after the edge that accepts start.
REQ-027 If latched col_sel >= num_qubit, SHALL treat every row as no-match, so ld_Q=ld_Q2=0 throughout SCAN while INIT is unchanged.
REQ-028 Outside SCAN, literals_out SHALL be all 00 and phase_out SHALL be 0.
REQ-029 start asserted in the same cycle as done SHALL be ignored; a new pass requires start in IDLE.
REQ-030 A write and a start in the same IDLE cycle SHALL both take effect, and the pass SHALL see the new row.

Reset
REQ-031 On rst_new=1, SHALL asynchronously force state=IDLE, ptr=0, latched col_sel=0 and every row = literals 00, phase 0.
REQ-032 During and after reset, all outputs SHALL be 0 (ld_Q, ld_Q2, load_Q_mux, load_rotate_Q, busy, done, literals_out, phase_out).
REQ-033 Reset mid-pass SHALL abort the pass with no done pulse.

Structure
REQ-034 SHALL place the literal encoding constants (LIT_I/Z/X/Y) and the FSM state enum in the shared qcm package.
REQ-035 SHALL use one natural sub-module, row_bank (register file with write port and combinational read port); the FSM and select logic stay in the top.

Verification
REQ-036 Reset with num_qubit=4 -> all outputs 0; a pass run afterwards yields ld_Q/ld_Q2 only in INIT, then done at cycle 6.
REQ-037 Rows {XIII, ZIII, YIII, IZII}, col_sel=0, start -> INIT both strobes; SCAN ld_Q=1,0,1,0 and ld_Q2=0,1,1,0; done at cycle 6.
REQ-038 col_sel=5 with num_qubit=4 -> INIT strobes only, no SCAN strobes, done still at cycle 6.
REQ-039 wr_en pulsed at cycle 3 of a pass -> row bank unchanged; a second pass shows the original strobe pattern.
REQ-040 rst_new asserted at cycle 3 of a pass -> outputs 0 immediately, no done pulse, rows cleared.
REQ-041 start held high continuously -> passes run back-to-back with one IDLE cycle between done and the next INIT.

Source files
------------

// File: rtl/qcm_pkg.sv
// rtl/qcm_pkg.sv - shared Pauli literal encoding and row sequencer state enum
package qcm_pkg;

    localparam logic [1:0] LIT_I = 2'b00;
    localparam logic [1:0] LIT_Z = 2'b01;
    localparam logic [1:0] LIT_X = 2'b10;
    localparam logic [1:0] LIT_Y = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_SCAN,
        ST_DONE
    } seq_state_t;

    function automatic logic lit_has_x(input logic [1:0] lit);
        return (lit == LIT_X) || (lit == LIT_Y);
    endfunction

    function automatic logic lit_has_z(input logic [1:0] lit);
        return (lit == LIT_Z) || (lit == LIT_Y);
    endfunction

endpackage

// File: rtl/tableau_row_sequencer_row_bank.sv
// rtl/tableau_row_sequencer_row_bank.sv - stabilizer row register file, one write port, combinational read
module row_bank #(
    parameter int num_qubit = 4,
    parameter int addr_w    = 2
) (
    input  logic                       clk,
    input  logic                       rst_new,
    input  logic                       wr_en,
    input  logic [addr_w-1:0]          wr_addr,
    input  logic [num_qubit-1:0][1:0]  wr_literals,
    input  logic                       wr_phase,
    input  logic [addr_w-1:0]          rd_addr,
    output logic [num_qubit-1:0][1:0]  rd_literals,
    output logic                       rd_phase
);

    logic [num_qubit-1:0][1:0] lit_mem [num_qubit];
    logic [num_qubit-1:0]      phase_bits;

    // Addresses past the last row (non power-of-two banks) are dropped.
    always_ff @(posedge clk or posedge rst_new) begin
        if (rst_new) begin
            for (int i = 0; i < num_qubit; i++) begin
                lit_mem[i] <= '0;
            end
            phase_bits <= '0;
        end else if (wr_en && (int'(wr_addr) < num_qubit)) begin
            lit_mem[wr_addr]    <= wr_literals;
            phase_bits[wr_addr] <= wr_phase;
        end
    end

    assign rd_literals = lit_mem[rd_addr];
    assign rd_phase    = phase_bits[rd_addr];

endmodule

// File: rtl/tableau_row_sequencer.sv
// rtl/tableau_row_sequencer.sv - walks the stabilizer rows and drives Q/Q2 load strobes for one column
module tableau_row_sequencer
    import qcm_pkg::*;
#(
    parameter  int num_qubit = 4,
    localparam int addr_w    = (num_qubit > 1) ? $clog2(num_qubit) : 1,
    localparam int col_w     = addr_w + 1
) (
    input  logic                       clk,
    input  logic                       rst_new,
    input  logic                       start,
    input  logic [col_w-1:0]           col_sel,
    input  logic                       wr_en,
    input  logic [addr_w-1:0]          wr_addr,
    input  logic [num_qubit-1:0][1:0]  wr_literals,
    input  logic                       wr_phase,
    output logic [num_qubit-1:0][1:0]  literals_out,
    output logic                       phase_out,
    output logic                       ld_Q,
    output logic                       ld_Q2,
    output logic                       load_Q_mux,
    output logic                       load_rotate_Q,
    output logic                       busy,
    output logic                       done
);

    seq_state_t                state;
    logic [addr_w-1:0]         ptr;
    logic [col_w-1:0]          col_q;
    logic [num_qubit-1:0][1:0] row_lits;
    logic                      row_phase;
    logic                      col_ok;
    logic [1:0]                sel_lit;

    row_bank #(
        .num_qubit (num_qubit),
        .addr_w    (addr_w)
    ) u_row_bank (
        .clk         (clk),
        .rst_new     (rst_new),
        .wr_en       (wr_en && (state == ST_IDLE)),
        .wr_addr     (wr_addr),
        .wr_literals (wr_literals),
        .wr_phase    (wr_phase),
        .rd_addr     (ptr),
        .rd_literals (row_lits),
        .rd_phase    (row_phase)
    );

    always_ff @(posedge clk or posedge rst_new) begin
        if (rst_new) begin
            state <= ST_IDLE;
            ptr   <= '0;
            col_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_INIT;
                        col_q <= col_sel;
                    end
                end
                ST_INIT: begin
                    state <= ST_SCAN;
                    ptr   <= '0;
                end
                ST_SCAN: begin
                    if (ptr == addr_w'(num_qubit - 1)) begin
                        state <= ST_DONE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + addr_w'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // An out-of-range column matches nothing, so SCAN never strobes.
    assign col_ok = (col_q < col_w'(num_qubit));

    always_comb begin
        sel_lit = LIT_I;
        if (col_ok) begin
            sel_lit = row_lits[col_q[addr_w-1:0]];
        end
    end

    always_comb begin
        literals_out = {num_qubit{LIT_I}};
        phase_out    = 1'b0;
        ld_Q         = 1'b0;
        ld_Q2        = 1'b0;
        load_Q_mux   = 1'b0;
        done         = 1'b0;
        case (state)
            ST_INIT: begin
                ld_Q  = 1'b1;
                ld_Q2 = 1'b1;
            end
            ST_SCAN: begin
                literals_out = row_lits;
                phase_out    = row_phase;
                load_Q_mux   = 1'b1;
                ld_Q         = lit_has_x(sel_lit);
                ld_Q2        = lit_has_z(sel_lit);
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy          = (state != ST_IDLE);
    assign load_rotate_Q = 1'b0;

endmodule

// File: tb/tb_tableau_row_sequencer.sv
// tb/tb_tableau_row_sequencer.sv - scoreboard bench for tableau_row_sequencer
module tb_tableau_row_sequencer;

    localparam int NQ = 4;
    localparam int AW = 2;
    localparam int CW = 3;

    logic                clk = 1'b0;
    logic                rst_new;
    logic                start;
    logic [CW-1:0]       col_sel;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [NQ-1:0][1:0]  wr_literals;
    logic                wr_phase;
    logic [NQ-1:0][1:0]  literals_out;
    logic                phase_out, ld_Q, ld_Q2, load_Q_mux, load_rotate_Q, busy, done;

    tableau_row_sequencer #(.num_qubit(NQ)) dut (
        .clk           (clk),
        .rst_new       (rst_new),
        .start         (start),
        .col_sel       (col_sel),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_literals   (wr_literals),
        .wr_phase      (wr_phase),
        .literals_out  (literals_out),
        .phase_out     (phase_out),
        .ld_Q          (ld_Q),
        .ld_Q2         (ld_Q2),
        .load_Q_mux    (load_Q_mux),
        .load_rotate_Q (load_rotate_Q),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NQ-1:0][1:0] lits;
        logic               phase;
        logic               ld_q;
        logic               ld_q2;
        logic               mux;
        logic               done;
        int                 cyc;
    } rec_t;

    rec_t               exp_q[$];
    logic [NQ-1:0][1:0] m_lits [NQ];
    logic               m_phase [NQ];
    int                 remaining = 0;
    int                 cyc = 0;
    int                 checks = 0;
    int                 errors = 0;

    // Reference model: a pass occupies num_qubit+2 busy cycles (INIT, one per row, DONE);
    // the bank only accepts writes and starts while no pass is outstanding.
    always @(posedge clk or posedge rst_new) begin
        if (rst_new) begin
            for (int r = 0; r < NQ; r++) begin
                m_lits[r]  = '0;
                m_phase[r] = 1'b0;
            end
            remaining = 0;
            exp_q.delete();
        end else begin
            cyc++;
            if (remaining == 0) begin
                if (wr_en) begin
                    m_lits[wr_addr]  = wr_literals;
                    m_phase[wr_addr] = wr_phase;
                end
                if (start) begin
                    push_pass(int'(col_sel), cyc - 1);
                    remaining = NQ + 2;
                end
            end else begin
                remaining--;
            end
        end
    end

    task automatic push_pass(input int col, input int start_cyc);
        rec_t e;
        int   lit;
        e = '{lits: '0, phase: 1'b0, ld_q: 1'b1, ld_q2: 1'b1, mux: 1'b0, done: 1'b0,
              cyc: start_cyc + 1};
        exp_q.push_back(e);
        for (int r = 0; r < NQ; r++) begin
            lit = (col < NQ) ? int'(m_lits[r][col]) : 0;
            e = '{lits: m_lits[r], phase: m_phase[r], ld_q: (lit >= 2), ld_q2: (lit % 2 == 1),
                  mux: 1'b1, done: 1'b0, cyc: start_cyc + 2 + r};
            exp_q.push_back(e);
        end
        e = '{lits: '0, phase: 1'b0, ld_q: 1'b0, ld_q2: 1'b0, mux: 1'b0, done: 1'b1,
              cyc: start_cyc + NQ + 2};
        exp_q.push_back(e);
    endtask

    // Monitor: every busy cycle consumes one predicted record; idle cycles must be all-zero.
    always @(negedge clk) begin
        rec_t e;
        logic [NQ*2+6:0] got, want;
        #1;
        got = {literals_out, phase_out, ld_Q, ld_Q2, load_Q_mux, load_rotate_Q, busy, done};
        if (busy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_busy cyc=%0d got=%h", cyc, got);
            end else begin
                e = exp_q.pop_front();
                want = {e.lits, e.phase, e.ld_q, e.ld_q2, e.mux, 1'b0, 1'b1, e.done};
                if (got !== want || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pass_cycle cyc=%0d got=%h exp=%h exp_cyc=%0d", cyc, got, want, e.cyc);
                end
            end
        end else begin
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_pass cyc=%0d got=%h pending=%0d exp=0 pending", cyc, got, exp_q.size());
                exp_q.delete();
            end else if (got !== '0) begin
                errors++;
                $display("FAIL idle_outputs cyc=%0d got=%h exp=0", cyc, got);
            end
        end
    end

    task automatic write_row(input int addr, input logic [NQ-1:0][1:0] lits, input logic ph, input logic go);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_literals = lits; wr_phase = ph; start = go;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic run_pass(input int col);
        start = 1'b1; col_sel = CW'(col);
        @(negedge clk);
        start = 1'b0;
        repeat (NQ + 3) @(negedge clk);
    endtask

    initial begin
        rst_new = 1'b1; start = 1'b0; col_sel = '0; wr_en = 1'b0;
        wr_addr = '0; wr_literals = '0; wr_phase = 1'b0;
        repeat (3) @(negedge clk);
        rst_new = 1'b0;

        run_pass(0);

        // XIII, ZIII, YIII, IZII; the last write lands together with start.
        write_row(0, 8'h02, 1'b0, 1'b0);
        write_row(1, 8'h01, 1'b1, 1'b0);
        write_row(2, 8'h03, 1'b0, 1'b0);
        col_sel = '0;
        write_row(3, 8'h04, 1'b1, 1'b1);
        repeat (NQ + 3) @(negedge clk);

        run_pass(5);
        run_pass(1);

        // Writes mid-pass must be ignored.
        start = 1'b1; col_sel = '0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        write_row(0, 8'hFF, 1'b1, 1'b0);
        repeat (NQ + 2) @(negedge clk);
        run_pass(0);

        start = 1'b1; col_sel = CW'(1);
        repeat (3 * (NQ + 3)) @(negedge clk);
        start = 1'b0;
        repeat (NQ + 3) @(negedge clk);

        // Reset mid-pass aborts it and clears the bank.
        start = 1'b1; col_sel = '0;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        rst_new = 1'b1;
        repeat (2) @(negedge clk);
        rst_new = 1'b0;
        @(negedge clk);
        run_pass(0);

        for (int i = 0; i < 400; i++) begin
            wr_en       = ($urandom % 3) == 0;
            wr_addr     = AW'($urandom);
            wr_literals = (NQ*2)'($urandom);
            wr_phase    = 1'($urandom);
            start       = ($urandom % 4) == 0;
            col_sel     = CW'($urandom);
            rst_new     = ($urandom % 150) == 0;
            @(negedge clk);
            rst_new = 1'b0;
        end
        wr_en = 1'b0; start = 1'b0;
        repeat (NQ + 4) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_records got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
